free_list: RTL and testbench

- Integer physical-register free list: the allocator side of renaming.
- Supplies up to WIDTH fresh PRF indices per cycle to the rename stage (its new-destination operand).
- Accepts up to WIDTH previous-destination PRF indices per cycle from retirement for reuse.
- Snapshots its read pointer per branch checkpoint and restores it on mispredict recovery, so wrong-path allocations are reclaimed in one cycle.

---
 rtl/free_list.sv | 93 +++++++++
 tb/tb_free_list.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/free_list.sv
// rtl/free_list.sv - integer PRF free list with per-checkpoint head snapshots
// Up to WIDTH compacted allocations and frees per cycle; recovery restores head in one cycle.
module free_list #(
  parameter int PRF_SIZE = 64,
  parameter int ARF_SIZE = 32,
  parameter int WIDTH    = 4,
  parameter int CP_SIZE  = 4,
  parameter int FL_SIZE  = PRF_SIZE - ARF_SIZE,
  localparam int PRF_W   = $clog2(PRF_SIZE),
  localparam int IDX_W   = $clog2(FL_SIZE),
  localparam int PTR_W   = IDX_W + 1,
  localparam int CP_W    = $clog2(CP_SIZE)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [WIDTH-1:0]            alloc_req_i,
  output logic                        alloc_ready_o,
  output logic [WIDTH-1:0][PRF_W-1:0] alloc_prf_o,
  input  logic [WIDTH-1:0]            free_valid_i,
  input  logic [WIDTH-1:0][PRF_W-1:0] free_prf_i,
  input  logic                        check_i,
  input  logic [CP_W-1:0]             check_idx_i,
  input  logic                        recover_i,
  input  logic [CP_W-1:0]             recover_idx_i,
  output logic [PTR_W-1:0]            free_count_o
);

  logic [PRF_W-1:0] entry_q   [FL_SIZE];
  logic [PTR_W-1:0] cp_head_q [CP_SIZE];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [PTR_W-1:0] head_alloc, count_d;
  logic [PTR_W-1:0] n_alloc, n_free;
  logic [PTR_W-1:0] alloc_off [WIDTH];
  logic [PTR_W-1:0] free_off  [WIDTH];
  logic [WIDTH-1:0] free_keep;

  always_comb begin
    n_alloc   = '0;
    n_free    = '0;
    free_keep = '0;
    // Prefix counts compact the active lanes onto consecutive list slots.
    for (int i = 0; i < WIDTH; i++) begin
      alloc_off[i] = n_alloc;
      n_alloc      = n_alloc + PTR_W'(alloc_req_i[i]);
      free_keep[i] = free_valid_i[i] && (free_prf_i[i] != '0);
      free_off[i]  = n_free;
      n_free       = n_free + PTR_W'(free_keep[i]);
    end

    free_count_o  = tail_q - head_q;
    alloc_ready_o = (free_count_o >= n_alloc) && !recover_i;
    for (int i = 0; i < WIDTH; i++) begin
      alloc_prf_o[i] = entry_q[IDX_W'(head_q + alloc_off[i])];
    end

    head_alloc = alloc_ready_o ? head_q + n_alloc : head_q;
    head_d     = recover_i ? cp_head_q[recover_idx_i] : head_alloc;
    tail_d     = tail_q + n_free;
    count_d    = tail_d - head_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= PTR_W'(FL_SIZE);
      for (int i = 0; i < FL_SIZE; i++) begin
        entry_q[i] <= PRF_W'(ARF_SIZE + i);
      end
      for (int c = 0; c < CP_SIZE; c++) begin
        cp_head_q[c] <= '0;
      end
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      for (int i = 0; i < WIDTH; i++) begin
        if (free_keep[i]) begin
          entry_q[IDX_W'(tail_q + free_off[i])] <= free_prf_i[i];
        end
      end
      // Snapshot includes this cycle's grants so the branch and older lanes stay allocated.
      if (check_i && !recover_i) begin
        cp_head_q[check_idx_i] <= head_alloc;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      assert (count_d <= PTR_W'(FL_SIZE));
    end
  end

endmodule

// File: tb/tb_free_list.sv
// tb/tb_free_list.sv - directed and randomized checks of free_list against a queue-position model
// The model tracks absolute allocate/free positions in an unbounded map.
module tb_free_list;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic [3:0]      alloc_req_i = '0;
  logic            alloc_ready_o;
  logic [3:0][5:0] alloc_prf_o;
  logic [3:0]      free_valid_i = '0;
  logic [3:0][5:0] free_prf_i = '0;
  logic            check_i = 1'b0;
  logic [1:0]      check_idx_i = '0;
  logic            recover_i = 1'b0;
  logic [1:0]      recover_idx_i = '0;
  logic [5:0]      free_count_o;

  free_list dut (
    .clock         (clock),
    .reset         (reset),
    .alloc_req_i   (alloc_req_i),
    .alloc_ready_o (alloc_ready_o),
    .alloc_prf_o   (alloc_prf_o),
    .free_valid_i  (free_valid_i),
    .free_prf_i    (free_prf_i),
    .check_i       (check_i),
    .check_idx_i   (check_idx_i),
    .recover_i     (recover_i),
    .recover_idx_i (recover_idx_i),
    .free_count_o  (free_count_o)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  int mem [int];
  int head, tail;
  int cp [4];

  logic            obs_rdy;
  logic [5:0]      obs_cnt;
  logic [3:0][5:0] obs_prf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mem.delete();
    for (int i = 0; i < 32; i++) mem[i] = 32 + i;
    head = 0;
    tail = 32;
    for (int c = 0; c < 4; c++) cp[c] = 0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    alloc_req_i = '0; free_valid_i = '0; check_i = 1'b0; recover_i = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic cyc(input logic [3:0] req, input logic [3:0] fv, input logic [3:0][5:0] fp,
                     input bit chk, input int ci, input bit rec, input int ri);
    int cnt, n, k;
    bit rdy;
    @(negedge clock);
    alloc_req_i = req; free_valid_i = fv; free_prf_i = fp;
    check_i = chk; check_idx_i = 2'(ci); recover_i = rec; recover_idx_i = 2'(ri);
    #1;
    obs_rdy = alloc_ready_o; obs_cnt = free_count_o; obs_prf = alloc_prf_o;
    cnt = tail - head;
    n = $countones(req);
    rdy = (cnt >= n) && !rec;
    check("free_count", free_count_o, cnt);
    check("alloc_ready", alloc_ready_o, rdy);
    if (rdy) begin
      k = 0;
      for (int i = 0; i < 4; i++) begin
        if (req[i]) begin
          check("alloc_prf", alloc_prf_o[i], mem[head + k]);
          k++;
        end
      end
    end
    @(posedge clock);
    for (int i = 0; i < 4; i++) begin
      if (fv[i] && fp[i] != 0) begin
        mem[tail] = fp[i];
        tail++;
      end
    end
    if (rec) head = cp[ri];
    else begin
      if (rdy) head += n;
      if (chk) cp[ci] = head;
    end
  endtask

  initial begin
    int ri, hn, allowed, cnt;
    bit rec, rdy;
    logic [3:0] req, fv;
    logic [3:0][5:0] fp;

    // Reset and first full-width grant.
    do_reset();
    cyc(4'b1111, 4'b0, '0, 0, 0, 0, 0);
    check("reset_count", obs_cnt, 32);
    check("first_lane0", obs_prf[0], 32);
    check("first_lane3", obs_prf[3], 35);
    cyc(4'b0000, 4'b0, '0, 0, 0, 0, 0);
    check("count_after4", obs_cnt, 28);

    // Drain to empty, then a single-lane request is refused.
    for (int c = 0; c < 7; c++) cyc(4'b1111, 4'b0, '0, 0, 0, 0, 0);
    cyc(4'b0001, 4'b0, '0, 0, 0, 0, 0);
    check("empty_count", obs_cnt, 0);
    check("empty_refuse", obs_rdy, 0);

    // Sparse free lanes compact in lane order.
    cyc(4'b0000, 4'b0101, {6'd0, 6'd40, 6'd0, 6'd41}, 0, 0, 0, 0);
    cyc(4'b0111, 4'b0, '0, 0, 0, 0, 0);
    check("count2", obs_cnt, 2);
    check("refuse3", obs_rdy, 0);
    cyc(4'b0011, 4'b0, '0, 0, 0, 0, 0);
    check("grant_lane0", obs_prf[0], 41);
    check("grant_lane1", obs_prf[1], 40);

    // Gapped request.
    do_reset();
    cyc(4'b1010, 4'b0, '0, 0, 0, 0, 0);
    check("gap_lane1", obs_prf[1], 32);
    check("gap_lane3", obs_prf[3], 33);
    cyc(4'b0000, 4'b0, '0, 0, 0, 0, 0);
    check("gap_count", obs_count_dummy(obs_cnt), 30);

    // Checkpoint, wrong-path allocation, recovery with a same-cycle free.
    do_reset();
    cyc(4'b0011, 4'b0, '0, 1, 2, 0, 0);
    for (int c = 0; c < 3; c++) cyc(4'b1111, 4'b0, '0, 0, 0, 0, 0);
    cyc(4'b1111, 4'b0001, {6'd0, 6'd0, 6'd0, 6'd5}, 1, 1, 1, 2);
    check("recover_count_before", obs_cnt, 18);
    check("recover_ready", obs_rdy, 0);
    cyc(4'b0000, 4'b0, '0, 0, 0, 0, 0);
    check("recover_count", obs_cnt, 31);
    cyc(4'b0001, 4'b0, '0, 0, 0, 0, 0);
    check("recover_realloc", obs_prf[0], 34);

    // Freeing x0 is dropped.
    cyc(4'b0000, 4'b0010, '0, 0, 0, 0, 0);
    cyc(4'b0000, 4'b0, '0, 0, 0, 0, 0);
    check("x0_dropped", obs_cnt, 30);

    // Reset overrides a recover in the same cycle.
    @(negedge clock);
    reset = 1'b1; recover_i = 1'b1; recover_idx_i = 2'd2; alloc_req_i = '0; free_valid_i = '0;
    @(negedge clock);
    reset = 1'b0; recover_i = 1'b0;
    model_reset();
    cyc(4'b0001, 4'b0, '0, 0, 0, 0, 0);
    check("midreset_count", obs_cnt, 32);
    check("midreset_prf", obs_prf[0], 32);

    // Randomized traffic kept within legal occupancy.
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      req = 4'($urandom);
      ri  = $urandom_range(0, 3);
      rec = ($urandom_range(0, 15) == 0) && (cp[ri] <= tail) && (tail - cp[ri] <= 32);
      cnt = tail - head;
      rdy = (cnt >= $countones(req)) && !rec;
      hn  = rec ? cp[ri] : (rdy ? head + $countones(req) : head);
      allowed = 32 - (tail - hn);
      fv = 4'($urandom) & 4'($urandom);
      for (int i = 0; i < 4; i++) begin
        fp[i] = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
        if (fv[i] && fp[i] != 0) begin
          if (allowed > 0) allowed--;
          else fv[i] = 1'b0;
        end
      end
      cyc(req, fv, fp, $urandom_range(0, 3) == 0, $urandom_range(0, 3), rec, ri);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  function automatic logic [31:0] obs_count_dummy(input logic [5:0] v);
    return {26'd0, v};
  endfunction

endmodule
